data_mem_arbiter: RTL

Two-port arbiter and sequencer in front of the 16-bit data memory wrapper. It shares the single data-memory port between the core load/store unit (port 0) and the external loader/debug port (port 1). It accepts at most one access per cycle, registers the winning command onto the memory interface, and returns read data to the owning requester one cycle later. Fixed core priority includes an anti-starvation counter; round-robin is selectable by parameter.

---
 rtl/data_mem_arbiter_pkg.sv | 8 +
 rtl/data_mem_arbiter_arb_pick.sv | 31 +++
 rtl/data_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: port indices and default
// anti-starvation limit.
package data_mem_arbiter_pkg;
  localparam logic PORT_CORE        = 1'b0;
  localparam logic PORT_LOAD        = 1'b1;
  localparam int   MAX_WAIT_DEFAULT = 8;
  localparam int   WAIT_CW          = 8;
endpackage

// File: rtl/data_mem_arbiter_arb_pick.sv
// Combinational two-way winner select: a lone requester always wins, conflicts
// resolve by round-robin or by core priority with a forced loader override.
module arb_pick
  import data_mem_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0
) (
  input  logic [1:0] req,
  input  logic       rr_last,
  input  logic       force_p1,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (ROUND_ROBIN != 0) begin
          // the port that did not win last time takes the conflict
          gnt = (rr_last == PORT_LOAD) ? 2'b01 : 2'b10;
        end else begin
          gnt = force_p1 ? 2'b10 : 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of the data-memory wrapper: accept in N, issue the
// registered command in N+1, return load data to the owner in N+2.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ROUND_ROBIN = 0,
  parameter int MAX_WAIT    = MAX_WAIT_DEFAULT,
  parameter int AW          = 16,
  parameter int DW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rvalid,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rvalid,
  output logic [DW-1:0] p1_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic          p0_stall
);

  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               force_p1;
  logic               win_we;

  logic               rr_last_q, rr_last_d;
  logic [WAIT_CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [AW-1:0]      mem_addr_q, mem_addr_d;
  logic [DW-1:0]      mem_data_q, mem_data_d;
  logic               mem_we_q, mem_we_d;
  logic               owner_q, owner_d;
  logic               issue_valid_q, issue_valid_d;
  logic               rd_pending_q, rd_pending_d;
  logic               p0_rvalid_q, p0_rvalid_d;
  logic               p1_rvalid_q, p1_rvalid_d;
  logic [DW-1:0]      p0_rdata_q, p0_rdata_d;
  logic [DW-1:0]      p1_rdata_q, p1_rdata_d;

  // nothing is accepted while reset is held, so no access survives the flush
  assign req      = {p1_req, p0_req} & {2{~reset}};
  assign force_p1 = (wait_cnt_q == WAIT_CW'(MAX_WAIT));

  arb_pick #(.ROUND_ROBIN(ROUND_ROBIN)) u_arb_pick (
    .req      (req),
    .rr_last  (rr_last_q),
    .force_p1 (force_p1),
    .gnt      (gnt)
  );

  assign win_we = gnt[1] ? p1_we : p0_we;

  always_comb begin
    rr_last_d     = rr_last_q;
    wait_cnt_d    = wait_cnt_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_we_d      = 1'b0;
    owner_d       = owner_q;
    issue_valid_d = 1'b0;
    rd_pending_d  = 1'b0;
    p0_rvalid_d   = 1'b0;
    p1_rvalid_d   = 1'b0;
    p0_rdata_d    = p0_rdata_q;
    p1_rdata_d    = p1_rdata_q;

    if (p1_req && !gnt[1]) begin
      if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
    end

    if (gnt != 2'b00) begin
      rr_last_d     = gnt[1];
      mem_addr_d    = gnt[1] ? p1_addr  : p0_addr;
      mem_data_d    = gnt[1] ? p1_wdata : p0_wdata;
      mem_we_d      = win_we;
      owner_d       = gnt[1];
      issue_valid_d = 1'b1;
      rd_pending_d  = ~win_we;
    end

    if (issue_valid_q && rd_pending_q) begin
      if (owner_q == PORT_LOAD) begin
        p1_rvalid_d = 1'b1;
        p1_rdata_d  = mem_q;
      end else begin
        p0_rvalid_d = 1'b1;
        p0_rdata_d  = mem_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_q     <= PORT_LOAD;
      wait_cnt_q    <= '0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_we_q      <= 1'b0;
      owner_q       <= PORT_CORE;
      issue_valid_q <= 1'b0;
      rd_pending_q  <= 1'b0;
      p0_rvalid_q   <= 1'b0;
      p1_rvalid_q   <= 1'b0;
      p0_rdata_q    <= '0;
      p1_rdata_q    <= '0;
    end else begin
      rr_last_q     <= rr_last_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_we_q      <= mem_we_d;
      owner_q       <= owner_d;
      issue_valid_q <= issue_valid_d;
      rd_pending_q  <= rd_pending_d;
      p0_rvalid_q   <= p0_rvalid_d;
      p1_rvalid_q   <= p1_rvalid_d;
      p0_rdata_q    <= p0_rdata_d;
      p1_rdata_q    <= p1_rdata_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_stall  = p0_req & ~gnt[0];
  assign p0_rvalid = p0_rvalid_q;
  assign p1_rvalid = p1_rvalid_q;
  assign p0_rdata  = p0_rdata_q;
  assign p1_rdata  = p1_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign mem_we    = mem_we_q;

endmodule
